// File: rtl/sync_fifo_pkg.sv
// Shared constants and elaboration-time helpers for the sync_fifo_flags FIFO.
// Used by both the default build and the SYNC_FIFO_ERR_EN build.
package sync_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Occupancy needs one extra bit so that DEPTH itself can be represented.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int data_w, input int depth,
                                      input int afull_th, input int aempty_th);
    return (data_w >= 1) && is_pow2(depth) &&
           (afull_th >= 1) && (afull_th <= depth) &&
           (aempty_th >= 0) && (aempty_th <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage for sync_fifo_flags.
// One write port and one registered read port that holds its value between reads.
module sync_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array has no reset so it can map to RAM; only the output register is reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_flags.sv
// Parametrised single-clock FIFO with occupancy count and threshold flags.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow flags and err_clr.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        rd_en,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [count_w(DEPTH)-1:0]   count
`ifdef SYNC_FIFO_ERR_EN
  ,
  input  logic                        err_clr,
  output logic                        overflow,
  output logic                        underflow
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = count_w(DEPTH);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AEMPTY_TH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  if (!params_legal(DATA_W, DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
    $error("sync_fifo_flags: illegal DATA_W/DEPTH/threshold parameters");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rd_valid_q;
  logic             full_s, empty_s;
  logic             wr_accept, rd_accept;

  // Acceptance is judged from the registered count, so a full FIFO never
  // accepts a write even when a read drains it in the same cycle.
  assign full_s    = (count_q == CNT_FULL);
  assign empty_s   = (count_q == '0);
  assign wr_accept = wr_en && !full_s;
  assign rd_accept = rd_en && !empty_s;

  always_comb begin
    // NOTE: defaults first so every path assigns every signal; no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_accept && !rd_accept)      count_d = count_q + CNT_ONE;
    else if (rd_accept && !wr_accept) count_d = count_q - CNT_ONE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_accept;
    end
  end

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .re_i    (rd_accept),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_q >= CNT_AF);
  assign almost_empty = (count_q <= CNT_AE);

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A clear wins over a set arriving in the same cycle.
  always_comb begin
    overflow_d  = err_clr ? 1'b0 : (overflow_q  | (wr_en & full_s));
    underflow_d = err_clr ? 1'b0 : (underflow_q | (rd_en & empty_s));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised single-clock FIFO, successor to the fixed 8-bit FIFO used by the current verification environment. Adds configurable data width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, and optional sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain and is the FIFO instance targeted by the next-generation bench.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AFULL_TH, DEPTH-2, almost_full asserted when count ≥ AFULL_TH (1..DEPTH)
- AEMPTY_TH, 2, almost_empty asserted when count ≤ AEMPTY_TH (0..DEPTH-1)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- wr_data  in  DATA_W  write data, sampled with wr_en
- rd_en  in  1  read request
- rd_data  out  DATA_W  read data, registered
- rd_valid  out  1  rd_data valid this cycle (one-cycle pulse per accepted read)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_TH
- almost_empty  out  1  count ≤ AEMPTY_TH
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- err_clr  in  1  clears sticky error flags (only with SYNC_FIFO_ERR_EN)
- overflow  out  1  sticky: write attempted while full (only with SYNC_FIFO_ERR_EN)
- underflow  out  1  sticky: read attempted while empty (only with SYNC_FIFO_ERR_EN)

## Operation
- Write accepted iff wr_en && !full at the clock edge; wr_data stored at wr_ptr, wr_ptr increments modulo DEPTH.
- Read accepted iff rd_en && !empty; entry at rd_ptr is registered onto rd_data, rd_ptr increments modulo DEPTH.
- full/empty are evaluated from the registered count before the edge. When full, a simultaneous read is accepted and the write is rejected; when empty, the write is accepted and the read is rejected (no fall-through).
- count: +1 on accepted write only, −1 on accepted read only, unchanged on both or neither. Never exceeds DEPTH, never below 0.
- Pointers are $clog2(DEPTH) bits and wrap naturally; no special case at wrap.
- All status outputs are decoded from the count register only (glitch-free, no combinational path from wr_en/rd_en).
- Rejected requests have no effect on state other than the error flags.
- Storage is not reset; contents after reset are undefined and unobservable.

## Timing
- Reset (async assert, sync release at the next edge): pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
- Read latency: rd_valid=1 and rd_data valid in the cycle after an accepted read; rd_valid=0 otherwise; rd_data holds its last value when rd_valid=0.
- Write-to-read: a word written at edge N is readable (empty=0) in cycle N+1; the earliest rd_valid is at edge N+2.
- Status flags update one cycle after the accepted operation that changes count.
- Reset asserted mid-operation discards all contents and any pending rd_valid immediately.

## Configuration
- SYNC_FIFO_ERR_EN defined: overflow sets on wr_en && full, underflow sets on rd_en && empty; both stay set until err_clr=1 (clear has priority over a same-cycle set) or reset.
- Not defined: err_clr, overflow and underflow ports are absent; rejected requests are silently dropped.

## Structure
- Package sync_fifo_pkg: default DATA_W/DEPTH constants, a count-width function ($clog2(DEPTH)+1), and the elaboration-time parameter legality checks (power-of-two depth, threshold ranges).
- One sub-module: sync_fifo_mem, a simple dual-port array (one write port, one registered read port) with DATA_W/DEPTH parameters. Control, count and flags stay in the top.

## Test plan
- Reset, then read with rd_en=1 on empty → underflow=1 (ERR_EN), rd_valid stays 0, count=0, empty=1.
- Write 0x01..0x10 (DEPTH=16) → full=1 after 16th, count=16, almost_full=1 from count 14; 17th write → overflow=1, data dropped.
- Drain all 16 → rd_data 0x01..0x10 in order, each with a one-cycle rd_valid one cycle after its rd_en; almost_empty=1 from count 2; empty=1 at end.
- Simultaneous wr_en/rd_en at count=5 for 20 cycles → count stays 5, pointers wrap, data order preserved.
- Full with wr_en=rd_en=1 → read accepted, write rejected, count=15; empty with both → write accepted, count=1, no rd_valid.
- Assert rst after 7 writes and mid-read → all outputs at reset values immediately; post-release write 0xAA then read returns 0xAA.
